instr_loader: RTL and testbench

- Boot-time writer for the instruction memory that the fetch stage reads from.
- Receives a byte stream over a valid/ready handshake and assembles little-endian `INSTR_LEN` (32-bit) instruction words.
- Drives the instruction memory write port at sequential byte addresses, stepping by 4 exactly as the PC does.
- Holds the core (fetch PC) in reset via core_hold until a load completes.

---
 rtl/instr_loader.sv | 187 ++++++++++++++++++
 tb/tb_instr_loader.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader
// ------------
// Boot-time writer for the instruction memory read by the fetch stage.
// A byte stream arrives over a valid/ready handshake. Every four bytes are
// assembled little-endian into one instruction word. Each word is written
// to the instruction memory at the next byte address, stepping by 4 as the
// PC does. The core is held in reset through core_hold until a load
// finishes without error.
//
// Optional feature (macro INSTR_LOADER_CHECKSUM_EN):
//   After the last word, one more byte is accepted. It must equal the XOR
//   of every data byte in the load, otherwise error is raised.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       one-cycle pulse that begins a load (accepted in IDLE/DONE)
//   num_words   word count, sampled when start is accepted
//   byte_in     stream data byte
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts a byte this cycle
//   wr_en       instruction memory write strobe, one cycle per word
//   wr_addr     byte address of the word being written
//   wr_data     instruction word being written
//   busy        load in progress
//   done        level, last load finished
//   error       level, last load faulted
//   core_hold   hold the fetch PC/core in reset

`ifndef WORD
`define WORD 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_loader #(
  parameter int               SIZE      = 1024,
  parameter logic [`WORD-1:0] BASE_ADDR = '0,
  parameter int               CNT_W     = $clog2(SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_words,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [`WORD-1:0]      wr_addr,
  output logic [`INSTR_LEN-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  core_hold
);

  localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
`ifdef INSTR_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       byte_idx;
  logic [CNT_W-1:0] word_cnt;
  logic             start_accept;
  logic             byte_xfer;
  logic             words_left;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // A start pulse only counts while the loader is idle or parked in DONE.
  // A start arriving in the cycle DONE is entered sees the old state and is
  // therefore dropped, which is the intended behaviour.
  assign start_accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign byte_xfer    = byte_valid && byte_ready;
  assign words_left   = (word_cnt != ONE_C);

  // Status outputs are pure decodes of the state. core_hold is released
  // only while parked in DONE after a clean load; any busy state or a
  // faulted load keeps the core held.
  always_comb begin
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_RECV:  begin byte_ready = 1'b1; busy = 1'b1; end
      S_WRITE: begin wr_en = 1'b1; busy = 1'b1; end
      S_DONE:  done = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK:   begin byte_ready = 1'b1; busy = 1'b1; end
`endif
      default: ;
    endcase
    core_hold = !((state == S_DONE) && !error);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic. Zero and oversize counts jump straight to DONE and
  // never write. WRITE always lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_accept) begin
          if ((num_words == '0) || (num_words > SIZE_C)) state_next = S_DONE;
          else                                           state_next = S_RECV;
        end
      end
      S_RECV: begin
        if (byte_xfer && (byte_idx == 2'd3)) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (words_left) state_next = S_RECV;
`ifdef INSTR_LOADER_CHECKSUM_EN
        else            state_next = S_CHK;
`else
        else            state_next = S_DONE;
`endif
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (byte_xfer) state_next = S_DONE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, word counter, address stepping and the error
  // flag. The address only advances when another word follows, so it never
  // points past the last legal word of the memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= 2'd0;
      word_cnt <= '0;
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
      error    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      if (start_accept) begin
        word_cnt <= num_words;
        wr_addr  <= BASE_ADDR;
        byte_idx <= 2'd0;
        error    <= (num_words > SIZE_C);
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum     <= 8'h00;
`endif
      end
      if ((state == S_RECV) && byte_xfer) begin
        wr_data[{byte_idx, 3'b000} +: 8] <= byte_in;
        byte_idx <= byte_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum     <= csum ^ byte_in;
`endif
      end
      if (state == S_WRITE) begin
        word_cnt <= word_cnt - ONE_C;
        byte_idx <= 2'd0;
        if (words_left) wr_addr <= wr_addr + `WORD'(4);
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      if ((state == S_CHK) && byte_xfer && (byte_in != csum)) error <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader
// ---------------
// Self-checking bench for instr_loader. Loads are driven with random data
// and random byte_valid gaps; the expected writes are derived from the
// byte list itself (word i = bytes 4i..4i+3 little-endian at BASE+4i).
// Honours INSTR_LOADER_CHECKSUM_EN in the same way as the design.

`timescale 1ns/1ps

module tb_instr_loader;

  localparam int          SIZE  = 1024;
  localparam int          CNT_W = $clog2(SIZE) + 1;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [CNT_W-1:0] num_words;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             busy;
  logic             done;
  logic             error;
  logic             core_hold;

  int checks   = 0;
  int failures = 0;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  bit          cap_lat[$];
  bit          prev_xfer;

  instr_loader #(.SIZE(SIZE), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset_n), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .error(error), .core_hold(core_hold)
  );

  always #5 clk = ~clk;

  // Write monitor: records every write strobe, plus whether a byte was
  // handed over in the cycle just before it.
  always @(negedge clk) begin
    if (wr_en) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
      cap_lat.push_back(prev_xfer);
    end
    prev_xfer = byte_valid && byte_ready;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pulse_start(input logic [CNT_W-1:0] n);
    start = 1'b1;
    num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_in = b;
    byte_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (byte_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_load(input int n, input logic [7:0] bytes[$], input int max_gap,
                          input bit mid_start, input bit bad_cks, output bit ok);
    bit got;
    logic [7:0] x;
    ok = 1'b1;
    x = 8'h00;
    cap_addr.delete(); cap_data.delete(); cap_lat.delete();
    pulse_start(CNT_W'(n));
    foreach (bytes[i]) begin
      if (mid_start && i == 2) begin
        byte_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        num_words = CNT_W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
      end
      send_byte(bytes[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, got);
      ok &= got;
      x ^= bytes[i];
    end
    if (CKS) begin
      send_byte(bad_cks ? (x ^ 8'h01) : x, 0, got);
      ok &= got;
    end
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = done;
    end
    ok &= got;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({byte_ready, wr_en, busy, done, error, core_hold} !== 6'b000001) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=000001", {byte_ready, wr_en, busy, done, error, core_hold});
    end
    checks++;
    if (wr_addr !== BASE || wr_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_bus got addr=%h data=%h exp addr=%h data=0", wr_addr, wr_data, BASE);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({byte_ready, wr_en, busy, done, error, core_hold} !== 6'b000001 || wr_addr !== BASE) begin
      failures++;
      $display("[TB] FAIL idle_hold got=%b addr=%h exp=000001 addr=%h",
               {byte_ready, wr_en, busy, done, error, core_hold}, wr_addr, BASE);
    end
    #1;
  endtask

  task automatic test_basic_load;
    logic [7:0] bytes[$];
    bit ok;
    for (int v = 0; v < 2; v++) begin
      bytes = '{8'h13, 8'h05, 8'h00, 8'h8B, 8'h00, 8'h00, 8'h00, 8'h14};
      run_load(2, bytes, 0, v == 1, 1'b0, ok);
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL basic_handshake variant=%0d got=0 exp=1", v); end
      checks++;
      if (cap_addr.size() != 2) begin
        failures++;
        $display("[TB] FAIL basic_write_count variant=%0d got=%0d exp=2", v, cap_addr.size());
      end else begin
        checks++;
        if (cap_addr[0] !== BASE || cap_data[0] !== 32'h8B000513 || !cap_lat[0]) begin
          failures++;
          $display("[TB] FAIL basic_word0 got addr=%h data=%h lat=%0d exp addr=%h data=8b000513 lat=1",
                   cap_addr[0], cap_data[0], cap_lat[0], BASE);
        end
        checks++;
        if (cap_addr[1] !== BASE + 32'd4 || cap_data[1] !== 32'h14000000 || !cap_lat[1]) begin
          failures++;
          $display("[TB] FAIL basic_word1 got addr=%h data=%h lat=%0d exp addr=%h data=14000000 lat=1",
                   cap_addr[1], cap_data[1], cap_lat[1], BASE + 32'd4);
        end
      end
      checks++;
      if ({done, busy, error, core_hold} !== 4'b1000) begin
        failures++;
        $display("[TB] FAIL basic_status variant=%0d got=%b exp=1000", v, {done, busy, error, core_hold});
      end
    end
  endtask

  task automatic test_zero_oversize;
    int seen;
    cap_addr.delete(); cap_data.delete(); cap_lat.delete();
    @(posedge clk); #1;
    pulse_start(CNT_W'(0));
    @(negedge clk);
    checks++;
    if ({done, busy, error, core_hold} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL zero_count_status got=%b exp=1000", {done, busy, error, core_hold});
    end
    #1;
    seen = 0;
    byte_valid = 1'b1;
    byte_in = 8'h5A;
    repeat (4) begin
      @(negedge clk);
      if (byte_ready) seen++;
    end
    byte_valid = 1'b0;
    checks++;
    if (seen != 0 || done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL done_ignores_bytes got ready_cycles=%0d done=%b exp 0 and 1", seen, done);
    end
    @(posedge clk); #1;
    pulse_start(CNT_W'(SIZE + 1));
    @(negedge clk);
    checks++;
    if ({done, busy, error, core_hold} !== 4'b1011) begin
      failures++;
      $display("[TB] FAIL oversize_status got=%b exp=1011", {done, busy, error, core_hold});
    end
    repeat (5) @(negedge clk);
    checks++;
    if (cap_addr.size() != 0 || core_hold !== 1'b1) begin
      failures++;
      $display("[TB] FAIL no_write_paths got writes=%0d hold=%b exp 0 and 1", cap_addr.size(), core_hold);
    end
    #1;
  endtask

  task automatic test_reset_mid;
    logic [7:0] bytes[$];
    logic [31:0] exp;
    bit ok;
    cap_addr.delete(); cap_data.delete(); cap_lat.delete();
    pulse_start(CNT_W'(1));
    send_byte(8'hAA, 0, ok);
    send_byte(8'hBB, 0, ok);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, wr_en, busy, done, error, core_hold} !== 6'b000001 ||
        wr_addr !== BASE || wr_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL mid_reset_values got=%b addr=%h data=%h exp=000001 addr=%h data=0",
               {byte_ready, wr_en, busy, done, error, core_hold}, wr_addr, wr_data, BASE);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cap_addr.size() != 0) begin
      failures++;
      $display("[TB] FAIL mid_reset_no_write got=%0d exp=0", cap_addr.size());
    end
    bytes = '{};
    for (int i = 0; i < 4; i++) bytes.push_back(8'($urandom));
    exp = {bytes[3], bytes[2], bytes[1], bytes[0]};
    run_load(1, bytes, 2, 1'b0, 1'b0, ok);
    checks++;
    if (!ok || cap_addr.size() != 1) begin
      failures++;
      $display("[TB] FAIL after_reset_load got ok=%0d writes=%0d exp ok=1 writes=1", ok, cap_addr.size());
    end else begin
      checks++;
      if (cap_addr[0] !== BASE || cap_data[0] !== exp || !cap_lat[0]) begin
        failures++;
        $display("[TB] FAIL after_reset_word got addr=%h data=%h lat=%0d exp addr=%h data=%h lat=1",
                 cap_addr[0], cap_data[0], cap_lat[0], BASE, exp);
      end
    end
  endtask

  task automatic test_random_loads;
    logic [7:0] bytes[$];
    logic [31:0] exp;
    bit ok;
    bit bad;
    int n;
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 6));
      bad = CKS && ($urandom_range(0, 1) == 1);
      bytes = '{};
      for (int i = 0; i < 4 * n; i++) bytes.push_back(8'($urandom));
      run_load(n, bytes, 3, 1'b0, bad, ok);
      checks++;
      if (!ok || cap_addr.size() != n) begin
        failures++;
        $display("[TB] FAIL rand_count load=%0d got ok=%0d writes=%0d exp ok=1 writes=%0d",
                 r, ok, cap_addr.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          exp = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
          checks++;
          if (cap_addr[i] !== BASE + 32'(4 * i) || cap_data[i] !== exp || !cap_lat[i]) begin
            failures++;
            $display("[TB] FAIL rand_word load=%0d idx=%0d got addr=%h data=%h lat=%0d exp addr=%h data=%h lat=1",
                     r, i, cap_addr[i], cap_data[i], cap_lat[i], BASE + 32'(4 * i), exp);
          end
        end
      end
      checks++;
      if ({done, busy, error, core_hold} !== {1'b1, 1'b0, bad, bad}) begin
        failures++;
        $display("[TB] FAIL rand_status load=%0d got=%b exp=%b", r, {done, busy, error, core_hold},
                 {1'b1, 1'b0, bad, bad});
      end
    end
  endtask

  task automatic test_full_size;
    logic [7:0] bytes[$];
    bit ok;
    int bad_words;
    bytes = '{};
    for (int i = 0; i < 4 * SIZE; i++) bytes.push_back(8'($urandom));
    run_load(SIZE, bytes, 0, 1'b0, 1'b0, ok);
    checks++;
    if (!ok || cap_addr.size() != SIZE) begin
      failures++;
      $display("[TB] FAIL full_count got ok=%0d writes=%0d exp ok=1 writes=%0d", ok, cap_addr.size(), SIZE);
    end else begin
      bad_words = 0;
      for (int i = 0; i < SIZE; i++)
        if (cap_addr[i] !== BASE + 32'(4 * i) ||
            cap_data[i] !== {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]} || !cap_lat[i])
          bad_words++;
      checks++;
      if (bad_words != 0 || cap_addr[SIZE-1] !== BASE + 32'(4 * (SIZE - 1))) begin
        failures++;
        $display("[TB] FAIL full_words got bad=%0d last_addr=%h exp bad=0 last_addr=%h",
                 bad_words, cap_addr[SIZE-1], BASE + 32'(4 * (SIZE - 1)));
      end
    end
    checks++;
    if ({done, busy, error, core_hold} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL full_status got=%b exp=1000", {done, busy, error, core_hold});
    end
  endtask

  task automatic test_checksum;
    logic [7:0] bytes[$];
    bit ok;
    for (int v = 0; v < 2; v++) begin
      bytes = '{8'h13, 8'h05, 8'h00, 8'h8B};
      run_load(1, bytes, 0, 1'b0, v == 1, ok);
      checks++;
      if (!ok || cap_addr.size() != 1) begin
        failures++;
        $display("[TB] FAIL cks_write variant=%0d got ok=%0d writes=%0d exp ok=1 writes=1", v, ok, cap_addr.size());
      end else begin
        checks++;
        if (cap_data[0] !== 32'h8B000513 || cap_addr[0] !== BASE) begin
          failures++;
          $display("[TB] FAIL cks_word variant=%0d got addr=%h data=%h exp addr=%h data=8b000513",
                   v, cap_addr[0], cap_data[0], BASE);
        end
      end
      checks++;
      if ({done, error, core_hold} !== {1'b1, v == 1, v == 1}) begin
        failures++;
        $display("[TB] FAIL cks_status variant=%0d got=%b exp=%b", v, {done, error, core_hold},
                 {1'b1, v == 1, v == 1});
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    reset_n = 1'b0;
    start = 1'b0;
    num_words = '0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    prev_xfer = 1'b0;
    test_reset();
    test_basic_load();
    test_zero_oversize();
    test_reset_mid();
    test_random_loads();
    test_full_size();
    if (CKS) test_checksum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
